sync_pulse_meter: RTL and testbench
===================================

Name: sync_pulse_meter

Overview:
- Consumer stage in the clk_b domain, directly downstream of the clk_a->clk_b synchronizer; input is the already-synchronized signal_sync.
- Rejects glitches shorter than MIN_W cycles and measures the width of each accepted high pulse in clock cycles.
- Hands each measurement to the next stage through a one-entry valid/ready output slot, with an event counter and a sticky drop flag.

Parameters:
CNT_W, 8, width of the pulse-width counter and width_out; counter saturates at 2^CNT_W-1
MIN_W, 2, minimum high cycles for a pulse to count as an event; legal range 1..2^CNT_W-1
EVT_W, 8, width of the accepted-event counter evt_cnt; wraps modulo 2^EVT_W

Ports:
clk  input  1  clock (clk_b domain)
rst  input  1  asynchronous, active-high reset
signal_sync  input  1  synchronized level from the CDC stage
ready  input  1  downstream accepts the slot contents when high at a posedge with valid=1
valid  output  1  output slot holds an unconsumed measurement
width_out  output  CNT_W  high-time in cycles of the delivered pulse, stable while valid=1
evt_cnt  output  EVT_W  number of pulses loaded into the slot since reset
overflow  output  1  sticky; set when an accepted pulse is lost because the slot is full
busy  output  1  high while the FSM is in HIGH

Behaviour:
- Reset (async assert, sync release): FSM=ARM, width counter=0, valid=0, width_out=0, evt_cnt=0, overflow=0, busy=0.
- ARM: waits for signal_sync=0, then moves to IDLE. A pulse already high at reset release is never measured.
- IDLE:
  - signal_sync=1 -> HIGH, counter=1.
  - signal_sync=0 -> stay.
- HIGH, signal_sync=1: counter+1, saturating at 2^CNT_W-1; stay.
- HIGH, signal_sync=0 (the decision cycle): next state IDLE, counter cleared.
  - counter < MIN_W: glitch; no output change.
  - counter >= MIN_W: the pulse is accepted.
    - Slot free (valid=0, or valid=1 and ready=1 this cycle): width_out<=counter, valid<=1, evt_cnt<=evt_cnt+1 (wrap).
    - Slot full (valid=1, ready=0): the pulse is dropped; overflow<=1; evt_cnt, width_out and valid are unchanged.
- Latency: width_out, valid and evt_cnt update at the posedge that ends the decision cycle, i.e. one cycle after the first low sample.
- Handshake:
  - Transfer occurs at a posedge where valid=1 and ready=1.
  - valid falls at that edge unless a new pulse loads in the same cycle. In that case valid stays 1 and width_out takes the new value.
  - width_out and valid never change while valid=1 and ready=0.
  - ready is ignored when valid=0.
- Back-to-back pulses: a pulse may start in the cycle after the decision cycle. Minimum event spacing is MIN_W+1 cycles.
- overflow clears only on rst.
- busy equals (state==HIGH) and is registered with the state.
- Reset mid-pulse or with valid pending: everything returns to reset values immediately; the pending measurement is lost without setting overflow.

Test Plan:
1. CNT_W=4, MIN_W=2, ready=1; signal_sync high 3 cycles then low -> valid=1 for exactly 1 cycle, one cycle after the first low sample; width_out=3; evt_cnt=1; overflow=0.
2. Signal_sync high 1 cycle (glitch), then low for 5 cycles -> valid stays 0, evt_cnt=0, busy high for 1 cycle only.
3. CNT_W=4; signal_sync high 20 cycles -> width_out=15 (saturated), evt_cnt=1.
4. ready=0; pulses of 3 then 4 cycles -> valid=1 and width_out=3 held through the second pulse, overflow=1, evt_cnt=1. Then ready=1 for one cycle -> valid=0 on the next cycle.
5. valid=1 holding width 3; ready asserted exactly in the decision cycle of a 5-cycle pulse -> valid stays 1, width_out=5, evt_cnt=2, overflow=0.
6. Assert rst while signal_sync=1 mid-pulse and valid=1 -> all outputs 0 asynchronously. Release with signal_sync high for 5 more cycles, then a 0, then a 4-cycle pulse -> only the 4-cycle pulse is reported (width_out=4, evt_cnt=1).

Source files
------------

// File: rtl/sync_pulse_meter.sv
`default_nettype none
// ============================================================================
// Module   : sync_pulse_meter
// Purpose  : clk_b-domain consumer of an already-synchronized level. Rejects
//            high pulses shorter than MIN_W cycles, measures the high time of
//            each accepted pulse (saturating counter) and offers the result
//            through a one-entry valid/ready slot. Keeps a wrapping count of
//            loaded events and a sticky flag for pulses lost to a full slot.
// Ports    : clk         - clock (clk_b domain)
//            rst         - asynchronous active-high reset
//            signal_sync - synchronized input level
//            ready       - downstream consumes the slot when valid=1
//            valid       - slot holds an unconsumed measurement
//            width_out   - high time of the delivered pulse, in cycles
//            evt_cnt     - pulses loaded into the slot since reset
//            overflow    - sticky: an accepted pulse was dropped (slot full)
//            busy        - FSM is measuring a high phase
// Revision : 1.0 - initial release
// ============================================================================
module sync_pulse_meter #(
    parameter int CNT_W = 8,
    parameter int MIN_W = 2,
    parameter int EVT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signal_sync,
    input  logic             ready,
    output logic             valid,
    output logic [CNT_W-1:0] width_out,
    output logic [EVT_W-1:0] evt_cnt,
    output logic             overflow,
    output logic             busy
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_MIN_W   = CNT_W'(MIN_W);

    typedef enum logic [1:0] {
        S_ARM  = 2'd0,
        S_IDLE = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_busy;

    logic             r_valid;
    logic [CNT_W-1:0] r_width;
    logic [EVT_W-1:0] r_evt;
    logic             r_ovf;

    logic             w_decide;
    logic             w_accept;
    logic             w_slot_free;
    logic             w_load;
    logic             w_drop;

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            // A level already high when reset releases is ignored: wait
            // for a low sample before any pulse can be measured.
            S_ARM: begin
                w_cnt_nxt = '0;
                if (!signal_sync) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (signal_sync) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (signal_sync) begin
                    if (r_cnt != C_CNT_MAX) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_ARM;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // The first low sample while HIGH is the decision cycle; r_cnt then
    // holds the complete (possibly saturated) high time.
    assign w_decide    = (r_state == S_HIGH) && !signal_sync;
    assign w_accept    = w_decide && (r_cnt >= C_MIN_W);
    // Slot counts as free when the current entry is consumed this edge.
    assign w_slot_free = !r_valid || ready;
    assign w_load      = w_accept && w_slot_free;
    assign w_drop      = w_accept && !w_slot_free;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ARM;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == S_HIGH);
        end
    end

    // ------------------------------------------------------------------
    // Output slot, event counter, sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_width <= '0;
            r_evt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_width <= r_cnt;
                r_evt   <= r_evt + EVT_W'(1);
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign valid     = r_valid;
    assign width_out = r_width;
    assign evt_cnt   = r_evt;
    assign overflow  = r_ovf;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sync_pulse_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_pulse_meter
// Purpose  : Self-checking bench for sync_pulse_meter (CNT_W=4, MIN_W=2).
//            Table of pulse records plus hand-written multi-cycle sequences;
//            expected measurements are queued when a pulse is driven and
//            compared when the DUT transfers them (valid & ready).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_pulse_meter;

    localparam int CNT_W = 4;
    localparam int MIN_W = 2;
    localparam int EVT_W = 8;

    logic             clk;
    logic             rst;
    logic             signal_sync;
    logic             ready;
    logic             valid;
    logic [CNT_W-1:0] width_out;
    logic [EVT_W-1:0] evt_cnt;
    logic             overflow;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int exp_evt = 0;

    typedef struct {
        int w;
        int evt;
    } exp_t;
    exp_t q[$];

    typedef struct {
        int hi;
        bit acc;
        int w;
    } vec_t;
    vec_t vecs[6];

    sync_pulse_meter #(
        .CNT_W(CNT_W),
        .MIN_W(MIN_W),
        .EVT_W(EVT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .signal_sync(signal_sync),
        .ready      (ready),
        .valid      (valid),
        .width_out  (width_out),
        .evt_cnt    (evt_cnt),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int w);
        exp_t e;
        exp_evt = (exp_evt + 1) % (1 << EVT_W);
        e.w = w;
        e.evt = exp_evt;
        q.push_back(e);
    endtask

    // Drives hi high cycles then the first low sample; returns just after
    // the decision edge. busy must be high after every high sample and low
    // after the decision edge. set_rdy raises ready for the decision cycle.
    task automatic apply_pulse(input int hi, input bit set_rdy);
        int busy_bad = 0;
        signal_sync = 1'b1;
        for (int i = 0; i < hi; i++) begin
            step();
            if (busy !== 1'b1) busy_bad++;
        end
        signal_sync = 1'b0;
        if (set_rdy) ready = 1'b1;
        step();
        chk("busy during high", busy_bad, 0);
        chk("busy after decision", int'(busy), 0);
    endtask

    // Scoreboard consumer: a transfer happens at the next posedge whenever
    // valid and ready are both high here.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (q.size() == 0) begin
                chk("unexpected transfer", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("xfer width_out", int'(width_out), e.w);
                chk("xfer evt_cnt", int'(evt_cnt), e.evt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        vecs[0] = '{hi: 3,  acc: 1'b1, w: 3};   // basic pulse
        vecs[1] = '{hi: 1,  acc: 1'b0, w: 0};   // glitch below MIN_W
        vecs[2] = '{hi: 20, acc: 1'b1, w: 15};  // saturates at 2^CNT_W-1
        vecs[3] = '{hi: 2,  acc: 1'b1, w: 2};   // exactly MIN_W
        vecs[4] = '{hi: 15, acc: 1'b1, w: 15};  // exactly max
        vecs[5] = '{hi: 16, acc: 1'b1, w: 15};  // one past max

        rst = 1'b1;
        signal_sync = 1'b0;
        ready = 1'b1;
        #12;
        chk("reset valid", int'(valid), 0);
        chk("reset width_out", int'(width_out), 0);
        chk("reset evt_cnt", int'(evt_cnt), 0);
        chk("reset overflow", int'(overflow), 0);
        chk("reset busy", int'(busy), 0);
        step();
        rst = 1'b0;
        step();
        step();

        // ---- table: ready held high ----
        foreach (vecs[k]) begin
            if (vecs[k].acc) push_exp(vecs[k].w);
            apply_pulse(vecs[k].hi, 1'b0);
            chk($sformatf("vec%0d valid at decision+1", k), int'(valid), int'(vecs[k].acc));
            chk($sformatf("vec%0d evt_cnt", k), int'(evt_cnt), exp_evt);
            bad = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                if (valid !== 1'b0) bad++;
            end
            chk($sformatf("vec%0d valid one cycle", k), bad, 0);
            chk($sformatf("vec%0d overflow", k), int'(overflow), 0);
        end

        // ---- slot full, freed exactly in the decision cycle ----
        ready = 1'b0;
        push_exp(3);
        apply_pulse(3, 1'b0);
        step();
        step();
        push_exp(5);
        apply_pulse(5, 1'b1);
        chk("refill valid", int'(valid), 1);
        chk("refill width_out", int'(width_out), 5);
        chk("refill evt_cnt", int'(evt_cnt), exp_evt);
        chk("refill overflow", int'(overflow), 0);
        step();
        chk("refill drained", int'(valid), 0);
        step();

        // ---- slot full, second pulse dropped ----
        ready = 1'b0;
        push_exp(3);
        apply_pulse(3, 1'b0);
        step();
        step();
        apply_pulse(4, 1'b0);
        step();
        chk("hold valid", int'(valid), 1);
        chk("hold width_out", int'(width_out), 3);
        chk("hold evt_cnt", int'(evt_cnt), exp_evt);
        chk("drop overflow", int'(overflow), 1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("drain valid", int'(valid), 0);
        step();
        chk("overflow sticky", int'(overflow), 1);

        // ---- async reset mid-pulse with a pending measurement ----
        push_exp(3);
        apply_pulse(3, 1'b0);
        step();
        signal_sync = 1'b1;
        step();
        step();
        chk("pre-reset busy", int'(busy), 1);
        chk("pre-reset valid", int'(valid), 1);
        #2;
        rst = 1'b1;
        q.delete();
        exp_evt = 0;
        #1;
        chk("async rst valid", int'(valid), 0);
        chk("async rst width_out", int'(width_out), 0);
        chk("async rst evt_cnt", int'(evt_cnt), 0);
        chk("async rst overflow", int'(overflow), 0);
        chk("async rst busy", int'(busy), 0);
        step();
        rst = 1'b0;
        ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy !== 1'b0 || valid !== 1'b0) bad++;
        end
        chk("armed pulse ignored", bad, 0);
        signal_sync = 1'b0;
        step();
        push_exp(4);
        apply_pulse(4, 1'b0);
        chk("post-reset valid", int'(valid), 1);
        chk("post-reset width_out", int'(width_out), 4);
        chk("post-reset evt_cnt", int'(evt_cnt), 1);
        step();
        step();

        chk("scoreboard drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
